// File: rtl/exe_mem_stage_pkg.sv
// ============================================================================
// exe_mem_stage_pkg : shared flag indices, buffer states and EXE/MEM payload
// Rev 1.0
// ============================================================================
`default_nettype none

package exe_mem_stage_pkg;

  localparam int PL_DATA_W     = 32;
  localparam int PL_REG_ADDR_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Encoding equals the buffered-entry count, so count is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [PL_DATA_W-1:0]     result;
    logic [PL_DATA_W-1:0]     st_val;
    logic [PL_REG_ADDR_W-1:0] dest;
    logic                     wb_en;
    logic                     mem_r;
    logic                     mem_w;
  } exe_mem_payload_t;

endpackage

`default_nettype wire

// File: rtl/exe_mem_stage_if.sv
// ============================================================================
// exe_mem_stage_if : EXE-side and MEM-side handshake bus of the EXE/MEM stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface exe_mem_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_alu_result;
  logic                  in_alu_c;
  logic                  in_alu_v;
  logic                  in_arith;
  logic                  in_s;
  logic                  in_wb_en;
  logic                  in_mem_r;
  logic                  in_mem_w;
  logic [REG_ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0]     in_st_val;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_st_val;
  logic                  out_wb_en;
  logic                  out_mem_r;
  logic                  out_mem_w;
  logic [REG_ADDR_W-1:0] out_dest;
  logic [3:0]            status;
  logic [1:0]            count;

  modport slave (
    input  in_valid, in_alu_result, in_alu_c, in_alu_v, in_arith, in_s,
           in_wb_en, in_mem_r, in_mem_w, in_dest, in_st_val, out_ready,
    output in_ready, out_valid, out_alu_result, out_st_val, out_wb_en,
           out_mem_r, out_mem_w, out_dest, status, count
  );

  modport master (
    output in_valid, in_alu_result, in_alu_c, in_alu_v, in_arith, in_s,
           in_wb_en, in_mem_r, in_mem_w, in_dest, in_st_val, out_ready,
    input  in_ready, out_valid, out_alu_result, out_st_val, out_wb_en,
           out_mem_r, out_mem_w, out_dest, status, count
  );
endinterface

`default_nettype wire

// File: rtl/exe_mem_stage_status_reg.sv
// ============================================================================
// status_reg : architectural NZCV register, updated on accepted S-bit ops
// Rev 1.0
// ============================================================================
`default_nettype none

module status_reg
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              upd_en,
  input  wire logic              arith,
  input  wire logic [DATA_W-1:0] result,
  input  wire logic              c,
  input  wire logic              v,
  output logic [3:0]             status
);

  logic [3:0] status_q;
  logic [3:0] status_d;

  always_comb begin
    status_d = status_q;
    if (upd_en) begin
      status_d[FLAG_N] = result[DATA_W-1];
      status_d[FLAG_Z] = (result == '0);
      // Logical/move ops leave C and V untouched.
      if (arith) begin
        status_d[FLAG_C] = c;
        status_d[FLAG_V] = v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= 4'b0000;
    else        status_q <= status_d;
  end

  assign status = status_q;

endmodule

`default_nettype wire

// File: rtl/exe_mem_stage.sv
// ============================================================================
// exe_mem_stage : EXE/MEM boundary with 2-entry elastic buffer and NZCV owner
// Rev 1.0
// ============================================================================
`default_nettype none

module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W     = PL_DATA_W,
  parameter int REG_ADDR_W = PL_REG_ADDR_W
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  exe_mem_stage_if.slave    bus
);

  buf_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  exe_mem_payload_t head_q, head_d;
  exe_mem_payload_t skid_q, skid_d;
  exe_mem_payload_t in_pl;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    in_pl        = '0;
    in_pl.result = bus.in_alu_result[DATA_W-1:0];
    in_pl.st_val = bus.in_st_val[DATA_W-1:0];
    in_pl.dest   = bus.in_dest[REG_ADDR_W-1:0];
    in_pl.wb_en  = bus.in_wb_en;
    in_pl.mem_r  = bus.in_mem_r;
    in_pl.mem_w  = bus.in_mem_w;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_pl;
        end else if (in_fire) begin
          skid_d  = in_pl;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready looks at the next state, keeping out_ready off the in_ready path.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  // Flags update in EXE order at acceptance, independent of MEM drain.
  status_reg #(
    .DATA_W (DATA_W)
  ) u_status_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .upd_en (in_fire & bus.in_s),
    .arith  (bus.in_arith),
    .result (bus.in_alu_result),
    .c      (bus.in_alu_c),
    .v      (bus.in_alu_v),
    .status (bus.status)
  );

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state_q != EMPTY);
  assign bus.count          = state_q;
  assign bus.out_alu_result = head_q.result;
  assign bus.out_st_val     = head_q.st_val;
  assign bus.out_dest       = head_q.dest;
  assign bus.out_wb_en      = head_q.wb_en;
  assign bus.out_mem_r      = head_q.mem_r;
  assign bus.out_mem_w      = head_q.mem_w;

endmodule

`default_nettype wire
